// File: rtl/sram16_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram16_responder_pkg
// Shared types and constants for the RISC5 memory-port SRAM responder.
//   state_e : top-level access phase (IDLE, LO half, HI half)
//   kind_e  : kind of the captured transaction (FETCH, LOAD, STORE)
//   WAIT_MIN: smallest legal number of cycles per SRAM half access
// -----------------------------------------------------------------------------
package sram16_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_e;

  // A half needs at least one cycle with we_n low plus one hold cycle.
  localparam int WAIT_MIN = 2;

  // Pick the 16-bit half of a 32-bit word that belongs to address bit 1.
  function automatic logic [15:0] lane_select(input logic [31:0] word, input logic upper);
    if (upper) begin
      return word[31:16];
    end else begin
      return word[15:0];
    end
  endfunction

endpackage

// File: rtl/sram16_responder_half_seq.sv
// -----------------------------------------------------------------------------
// sram16_half_seq
// Runs one SRAM half access: loads the address/data/lane strobes on i_start,
// counts WAIT cycles, keeps ce_n low for the whole half, and for writes holds
// we_n low in every cycle except the last so the address outlives we_n.
// A new i_start in the last cycle of a half chains straight into the next half.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : begin a half at this edge
//   i_addr          : halfword address for the half
//   i_write         : 1 = write half, 0 = read half
//   i_ub_n, i_lb_n  : byte lane enables for the half (active-low)
//   i_wdata         : write data for the half
//   i_sram_dq_i     : read data from the SRAM pads
//   o_last          : current cycle is the last cycle of the running half
//   o_rdata         : read data; the consumer samples it on the edge ending
//                     the half (when o_last is high)
//   sram_*          : registered SRAM pin strobes
// -----------------------------------------------------------------------------
module sram16_half_seq
  import sram16_responder_pkg::*;
#(
  parameter int WAIT = 2,
  parameter int AW   = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  input  logic          i_write,
  input  logic          i_ub_n,
  input  logic          i_lb_n,
  input  logic [15:0]   i_wdata,
  input  logic [15:0]   i_sram_dq_i,
  output logic          o_last,
  output logic [15:0]   o_rdata,
  output logic [AW-1:0] sram_a,
  output logic [15:0]   sram_dq_o,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  if (WAIT < WAIT_MIN) begin : g_wait_check
    $error("sram16_half_seq: WAIT must be at least WAIT_MIN");
  end

  localparam int            CW       = $clog2(WAIT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_a;
  logic [15:0]   r_dq_o;
  logic          r_oe;
  logic          r_ce_n;
  logic          r_we_n;
  logic          r_ub_n;
  logic          r_lb_n;

  // Half sequencer: strobe registers and the remaining-cycles down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= CNT_ZERO;
      r_a    <= {AW{1'b0}};
      r_dq_o <= 16'h0000;
      r_oe   <= 1'b0;
      r_ce_n <= 1'b1;
      r_we_n <= 1'b1;
      r_ub_n <= 1'b1;
      r_lb_n <= 1'b1;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_LOAD;
      r_a    <= i_addr;
      r_dq_o <= i_wdata;
      r_oe   <= i_write;
      r_ce_n <= 1'b0;
      // WAIT >= 2, so the first cycle of a half is never its last.
      r_we_n <= ~i_write;
      r_ub_n <= i_ub_n;
      r_lb_n <= i_lb_n;
    end else if (r_busy) begin
      if (r_cnt == CNT_ZERO) begin
        r_busy <= 1'b0;
        r_oe   <= 1'b0;
        r_ce_n <= 1'b1;
        r_we_n <= 1'b1;
        r_ub_n <= 1'b1;
        r_lb_n <= 1'b1;
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
        // Raise we_n entering the last cycle: write hold before the address moves.
        if (r_cnt == CNT_ONE) begin
          r_we_n <= 1'b1;
        end
      end
    end
  end

  assign o_last     = r_busy && (r_cnt == CNT_ZERO);
  assign o_rdata    = i_sram_dq_i;
  assign sram_a     = r_a;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_we_n  = r_we_n;
  assign sram_ub_n  = r_ub_n;
  assign sram_lb_n  = r_lb_n;

endmodule

// File: rtl/sram16_responder.sv
// -----------------------------------------------------------------------------
// sram16_responder
// Target end of the RISC5 memory port. Serves instruction fetches, word
// loads/stores and byte loads/stores from a 16-bit asynchronous SRAM, splitting
// each 32-bit word into a LO and a HI half access. stallX is high while an
// access is in flight and comes from registered state only.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   adr           : CPU byte address (bits above AW alias)
//   rd, wr, ben   : load request, store request, byte qualifier
//   outbus        : store data (byte stores arrive lane-replicated)
//   inbus         : load result, held between loads
//   codebus       : fetch result, held between fetches
//   stallX        : responder busy
//   sram_a        : halfword address
//   sram_dq_o/_i  : write/read data, sram_dq_oe enables the pad driver
//   sram_ce_n, sram_we_n, sram_ub_n, sram_lb_n : active-low SRAM strobes
// -----------------------------------------------------------------------------
module sram16_responder
  import sram16_responder_pkg::*;
#(
  parameter int WAIT = 2,
  parameter int AW   = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   adr,
  input  logic          rd,
  input  logic          wr,
  input  logic          ben,
  input  logic [31:0]   outbus,
  output logic [31:0]   inbus,
  output logic [31:0]   codebus,
  output logic          stallX,
  output logic [AW-1:0] sram_a,
  output logic [15:0]   sram_dq_o,
  input  logic [15:0]   sram_dq_i,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  state_e        r_state;
  kind_e         r_kind;
  logic          r_byte;
  logic          r_sel_hi;
  logic [AW-2:0] r_adr_hi;
  logic [15:0]   r_hi_wdata;
  logic [15:0]   r_lo_data;
  logic [31:0]   r_inbus;
  logic [31:0]   r_codebus;
  logic          r_stall;

  state_e        w_state_nxt;
  kind_e         w_cap_kind;
  logic          w_cap_byte;
  logic          w_start;
  logic [AW-1:0] w_addr;
  logic          w_write;
  logic          w_ub_n;
  logic          w_lb_n;
  logic [15:0]   w_wdata;
  logic          w_last;
  logic [15:0]   w_rdata;

  // Decode the bus request; a store wins over a load when both are raised.
  always_comb begin
    w_cap_kind = KIND_FETCH;
    if (wr) begin
      w_cap_kind = KIND_STORE;
    end else if (rd) begin
      w_cap_kind = KIND_LOAD;
    end else begin
      w_cap_kind = KIND_FETCH;
    end
  end

  // ben only qualifies data accesses; fetches are always whole words.
  assign w_cap_byte = ben & (wr | rd);

  // Next-state and half-access launch parameters.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_addr      = {r_adr_hi, 1'b1};
    w_write     = 1'b0;
    w_ub_n      = 1'b0;
    w_lb_n      = 1'b0;
    w_wdata     = r_hi_wdata;
    case (r_state)
      ST_IDLE: begin
        // Every idle edge captures a transaction and launches its first half.
        w_start     = 1'b1;
        w_state_nxt = ST_LO;
        w_addr      = {adr[AW:2], w_cap_byte ? adr[1] : 1'b0};
        w_write     = wr;
        if (w_cap_byte) begin
          w_ub_n  = ~adr[0];
          w_lb_n  = adr[0];
          w_wdata = lane_select(outbus, adr[1]);
        end else begin
          w_ub_n  = 1'b0;
          w_lb_n  = 1'b0;
          w_wdata = outbus[15:0];
        end
      end
      ST_LO: begin
        if (w_last) begin
          if (r_byte) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = ST_HI;
            w_write     = (r_kind == KIND_STORE);
          end
        end else begin
          w_state_nxt = ST_LO;
        end
      end
      ST_HI: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HI;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, busy flag and capture of the transaction in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_stall    <= 1'b0;
      r_kind     <= KIND_FETCH;
      r_byte     <= 1'b0;
      r_sel_hi   <= 1'b0;
      r_adr_hi   <= {(AW-1){1'b0}};
      r_hi_wdata <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_IDLE) begin
        r_kind     <= w_cap_kind;
        r_byte     <= w_cap_byte;
        r_sel_hi   <= adr[1];
        r_adr_hi   <= adr[AW:2];
        r_hi_wdata <= outbus[31:16];
      end
    end
  end

  // Result registers: read data is taken on the edge that ends each half.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo_data <= 16'h0000;
      r_inbus   <= 32'h0000_0000;
      r_codebus <= 32'h0000_0000;
    end else if (w_last && (r_state == ST_LO)) begin
      if (!r_byte) begin
        r_lo_data <= w_rdata;
      end else if (r_kind == KIND_LOAD) begin
        r_inbus <= r_sel_hi ? {w_rdata, 16'h0000} : {16'h0000, w_rdata};
      end
    end else if (w_last && (r_state == ST_HI)) begin
      if (r_kind == KIND_LOAD) begin
        r_inbus <= {w_rdata, r_lo_data};
      end else if (r_kind == KIND_FETCH) begin
        r_codebus <= {w_rdata, r_lo_data};
      end
    end
  end

  sram16_half_seq #(
    .WAIT (WAIT),
    .AW   (AW)
  ) u_half_seq (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_addr      (w_addr),
    .i_write     (w_write),
    .i_ub_n      (w_ub_n),
    .i_lb_n      (w_lb_n),
    .i_wdata     (w_wdata),
    .i_sram_dq_i (sram_dq_i),
    .o_last      (w_last),
    .o_rdata     (w_rdata),
    .sram_a      (sram_a),
    .sram_dq_o   (sram_dq_o),
    .sram_dq_oe  (sram_dq_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_we_n   (sram_we_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  assign inbus   = r_inbus;
  assign codebus = r_codebus;
  assign stallX  = r_stall;

endmodule
